fifo_rr_merge: RTL and testbench
================================

// Module: fifo_rr_merge
// PURPOSE
//   Round-robin merge controller: shares one downstream fifo_n (sink) among NUM_IN upstream
//   fifo_n instances (sources) in a CGRA PE input network. It sequences the sources' read
//   strobes and the sink's write strobe so neither FIFO is ever read-when-empty or
//   written-when-full. Each grant holds for up to BURST consecutive tokens, then rotates.
//   One registered data stage sits between the sources and the sink.
// PARAMETERS
//   DATA_SIZE  8  token width in bits
//   IDX_W      2  source index width; NUM_IN = 1<<IDX_W sources
//   BURST      2  max consecutive tokens taken from one owner before forced rotation (>=1)
// PORTS
//   clk      in   1                  clock, all state updates on posedge
//   rst      in   1                  asynchronous, active-high reset
//   inData   in   NUM_IN*DATA_SIZE   source outData buses; source i = bits [i*DATA_SIZE +: DATA_SIZE]
//   inEmpty  in   NUM_IN             source isEmpty flags
//   inRead   out  NUM_IN             source read strobes, one-hot or zero
//   outData  out  DATA_SIZE          sink inData (registered)
//   outWrite out  1                  sink write strobe
//   outFull  in   1                  sink isFull flag
//   grantIdx out  IDX_W              index of the current owner (registered)
//   tokCount out  16                 tokens delivered to sink (ARB_STATS_EN only)
// BEHAVIOUR
// - Reset (async): holdValid=0, outWrite=0, inRead=0, outData=0, owner=grantIdx=NUM_IN-1,
//   cnt=0, tokCount=0. First search after reset starts at source 0.
// - Output stage: register holdValid/outData. outWrite = holdValid && !outFull (combinational),
//   so a write is never issued while the sink is full. drain = outWrite.
// - canTake = !holdValid || drain.
// - Selection (combinational each cycle):
//   * keep: cnt < BURST && !inEmpty[owner] -> sel = owner.
//   * otherwise rotate: sel = first i with !inEmpty[i], scanning owner+1, owner+2, ...
//     modulo NUM_IN, including owner itself last.
//   * No source ready -> no selection.
// - inRead[sel] = 1 only when a selection exists && canTake. All other bits are 0.
//   Data is sampled from inData[sel] in that same cycle, since fifo_n outData is combinational.
// - Posedge with read: outData<=inData[sel], holdValid<=1.
//   If sel==owner: cnt<=cnt+1. Else owner<=sel, cnt<=1. grantIdx follows owner.
// - Posedge with drain and no read: holdValid<=0.
// - Read and drain in the same cycle: the stage reloads, holdValid stays 1, giving one token
//   per cycle throughput.
// - Latency: source read at cycle N -> earliest sink write at cycle N+1.
// - Sink full: holdValid stays 1 with data stable; no inRead is issued; owner and cnt freeze.
// - Owner empties mid-burst: rotate immediately. cnt does not carry over.
// - Owner is the only ready source and cnt==BURST: the rotate scan re-selects it and cnt<=1.
//   No idle bubble.
// - Index arithmetic is IDX_W bits and wraps naturally (NUM_IN-1 + 1 -> 0).
// - Reset mid-transfer: the held token is discarded. Sources are not re-read for it.
// CONFIGURATION
// - ARB_STATS_EN defined:
//   * tokCount port present.
//   * Increments by 1 on every posedge where outWrite=1.
//   * Wraps from 16'hFFFF to 0.
//   * Cleared by rst.
// - ARB_STATS_EN undefined: the tokCount port and its counter are absent. All other
//   behaviour is identical.
// TESTING
// - Reset, then all sources empty for 10 cycles -> inRead=0, outWrite=0, grantIdx=3.
// - NUM_IN=4, BURST=2, all sources preloaded with 4 tokens (src i data = 8'hi0..i3),
//   sink never full -> sink order 00,01,10,11,20,21,30,31,02,03,... at one token per cycle.
// - Only source 2 holds 5 tokens -> all 5 delivered back-to-back, grantIdx=2 throughout.
// - Sink outFull=1 for 3 cycles while holdValid=1 -> outWrite=0, outData stable,
//   inRead=0; first token delivered on the cycle outFull drops.
// - Source 1 empties after 1 token of its burst while source 3 is ready ->
//   the next inRead is on source 3.
// - Assert rst mid-stream with holdValid=1 -> outWrite=0 the same cycle; after release the
//   scan restarts at source 0. With ARB_STATS_EN, tokCount=0 after reset and equals the
//   number of tokens written.

Source files
------------

// File: rtl/fifo_rr_merge.sv
// Round-robin merge of NUM_IN source FIFOs into one sink FIFO through a single registered stage.
// Optional token counter output tokCount is built when ARB_STATS_EN is defined.
module fifo_rr_merge #(
    parameter int DATA_SIZE = 8,
    parameter int IDX_W     = 2,
    parameter int BURST     = 2
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [(1 << IDX_W)*DATA_SIZE-1:0]    inData,
    input  logic [(1 << IDX_W)-1:0]              inEmpty,
    output logic [(1 << IDX_W)-1:0]              inRead,
    output logic [DATA_SIZE-1:0]                 outData,
    output logic                                 outWrite,
    input  logic                                 outFull,
    output logic [IDX_W-1:0]                     grantIdx
`ifdef ARB_STATS_EN
    ,
    output logic [15:0]                          tokCount
`endif
);

    localparam int NUM_IN = 1 << IDX_W;
    localparam int CNT_W  = (BURST < 1) ? 1 : $clog2(BURST + 1);
    localparam logic [CNT_W-1:0] BURST_C = CNT_W'(BURST);

    logic                 hold_valid_q;
    logic [DATA_SIZE-1:0] out_data_q;
    logic [IDX_W-1:0]     owner_q, owner_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    logic                 drain;
    logic                 can_take;
    logic                 keep;
    logic                 sel_valid;
    logic [IDX_W-1:0]     sel;
    logic                 rd;
    logic [DATA_SIZE-1:0] rd_data;

    assign outWrite = hold_valid_q && !outFull;
    assign drain    = outWrite;
    assign can_take = !hold_valid_q || drain;

    // cnt_q is 0 only before the first grant, so the first search skips the keep path
    // and scans from owner+1, i.e. source 0.
    assign keep = (cnt_q != '0) && (cnt_q < BURST_C) && !inEmpty[owner_q];

    always_comb begin
        logic [IDX_W-1:0] idx;
        sel       = owner_q;
        sel_valid = 1'b0;
        idx       = '0;
        if (keep) begin
            sel       = owner_q;
            sel_valid = 1'b1;
        end else begin
            for (int k = 1; k <= NUM_IN; k++) begin
                idx = owner_q + IDX_W'(k);
                if (!sel_valid && !inEmpty[idx]) begin
                    sel       = idx;
                    sel_valid = 1'b1;
                end
            end
        end
    end

    assign rd = sel_valid && can_take;

    always_comb begin
        inRead = '0;
        if (rd) begin
            inRead[sel] = 1'b1;
        end
    end

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (IDX_W'(i) == sel) begin
                rd_data = inData[i*DATA_SIZE +: DATA_SIZE];
            end
        end
    end

    always_comb begin
        owner_d = owner_q;
        cnt_d   = cnt_q;
        if (rd) begin
            if (keep) begin
                cnt_d = cnt_q + CNT_W'(1);
            end else begin
                // A rotation that lands back on the owner still starts a fresh burst.
                owner_d = sel;
                cnt_d   = CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_valid_q <= 1'b0;
            out_data_q   <= '0;
            owner_q      <= IDX_W'(NUM_IN - 1);
            cnt_q        <= '0;
        end else begin
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            if (rd) begin
                out_data_q   <= rd_data;
                hold_valid_q <= 1'b1;
            end else if (drain) begin
                hold_valid_q <= 1'b0;
            end
        end
    end

    assign outData  = out_data_q;
    assign grantIdx = owner_q;

`ifdef ARB_STATS_EN
    logic [15:0] tok_count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tok_count_q <= '0;
        end else if (outWrite) begin
            tok_count_q <= tok_count_q + 16'd1;
        end
    end

    assign tokCount = tok_count_q;
`endif

endmodule

// File: tb/tb_fifo_rr_merge.sv
// Bench for fifo_rr_merge: source/sink FIFO models, a transaction-level arbitration model,
// and a scoreboard monitor that checks every sink write. Honours ARB_STATS_EN when defined.
module tb_fifo_rr_merge;

    localparam int DATA_SIZE = 8;
    localparam int IDX_W     = 2;
    localparam int BURST     = 2;
    localparam int NUM_IN    = 1 << IDX_W;

    logic                          clk;
    logic                          rst;
    logic [NUM_IN*DATA_SIZE-1:0]   in_data;
    logic [NUM_IN-1:0]             in_empty;
    logic [NUM_IN-1:0]             in_read;
    logic [DATA_SIZE-1:0]          out_data;
    logic                          out_write;
    logic                          out_full;
    logic [IDX_W-1:0]              grant_idx;
`ifdef ARB_STATS_EN
    logic [15:0]                   tok_count;
`endif

    fifo_rr_merge #(
        .DATA_SIZE(DATA_SIZE),
        .IDX_W    (IDX_W),
        .BURST    (BURST)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .inData  (in_data),
        .inEmpty (in_empty),
        .inRead  (in_read),
        .outData (out_data),
        .outWrite(out_write),
        .outFull (out_full),
        .grantIdx(grant_idx)
`ifdef ARB_STATS_EN
        ,
        .tokCount(tok_count)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_errors = 0;
    int n_writes = 0;

    logic [7:0] src_q [NUM_IN][$];
    int         nxt   [NUM_IN];
    logic [7:0] exp_q [$];
    logic [7:0] sink_log [$];

    // Arbitration model state: current owner, tokens taken in its burst, staged token.
    int         m_owner;
    int         m_cnt;
    bit         m_held;
    logic [7:0] m_hold_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic load(input int i, input int n);
        for (int k = 0; k < n; k++) begin
            src_q[i].push_back(8'(i*16 + (nxt[i] % 16)));
            nxt[i]++;
        end
    endtask

    task automatic drive_src();
        for (int i = 0; i < NUM_IN; i++) begin
            in_empty[i] = (src_q[i].size() == 0);
            in_data[i*DATA_SIZE +: DATA_SIZE] = (src_q[i].size() != 0) ? src_q[i][0] : 8'($urandom);
        end
    endtask

    // Keep the owner while its burst is unfinished and it has data; otherwise take the
    // next non-empty source after the owner in circular order (owner itself last).
    function automatic int pick();
        if (m_cnt > 0 && m_cnt < BURST && src_q[m_owner].size() > 0) return m_owner;
        for (int k = 1; k <= NUM_IN; k++) begin
            int i;
            i = (m_owner + k) % NUM_IN;
            if (src_q[i].size() > 0) return i;
        end
        return -1;
    endfunction

    task automatic step(input bit full, input bit refill);
        int  s;
        bit  take;
        bit  cont;
        logic [7:0] tok;
        @(negedge clk);
        out_full = full;
        if (refill) begin
            for (int i = 0; i < NUM_IN; i++) begin
                if ($urandom_range(3) == 0 && src_q[i].size() < 6) load(i, 1);
            end
        end
        drive_src();
        #1;
        s    = pick();
        take = (s >= 0) && (!m_held || !full);
        chk("write_strobe", 32'(out_write), 32'(m_held && !full));
        chk("grant_idx", 32'(grant_idx), 32'(m_owner));
        if (m_held) chk("held_data", 32'(out_data), 32'(m_hold_data));
        chk("read_strobe", 32'(in_read), take ? (32'd1 << s) : 32'd0);
        if (!take && m_held && !full) m_held = 1'b0;
        if (take) begin
            cont = (s == m_owner) && m_cnt > 0 && m_cnt < BURST;
            tok  = src_q[s].pop_front();
            exp_q.push_back(tok);
            m_hold_data = tok;
            m_held      = 1'b1;
            if (cont) begin
                m_cnt++;
            end else begin
                m_owner = s;
                m_cnt   = 1;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b1;
        out_full = 1'b0;
        n_writes = 0;
        exp_q.delete();
        #1;
        chk("rst_write", 32'(out_write), 32'd0);
        chk("rst_grant", 32'(grant_idx), 32'(NUM_IN - 1));
        chk("rst_data", 32'(out_data), 32'd0);
        repeat (2) @(posedge clk);
        #2;
        rst     = 1'b0;
        m_owner = NUM_IN - 1;
        m_cnt   = 0;
        m_held  = 1'b0;
    endtask

    task automatic check_log(input string name, input logic [7:0] exp[$]);
        chk({name, "_count"}, 32'(sink_log.size()), 32'(exp.size()));
        for (int k = 0; k < exp.size() && k < sink_log.size(); k++) begin
            chk(name, 32'(sink_log[k]), 32'(exp[k]));
        end
    endtask

    // Scoreboard monitor: every sink write must match the oldest outstanding source read.
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clk);
            #3;
`ifdef ARB_STATS_EN
            chk("tok_count", 32'(tok_count), 32'(n_writes[15:0]));
`endif
            if (out_write === 1'b1) begin
                n_writes++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", 32'(out_data), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("sink_data", 32'(out_data), 32'(e));
                end
                sink_log.push_back(out_data);
            end
        end
    end

    initial begin
        logic [7:0] exp_log [$];
        int guard;
        rst      = 1'b0;
        out_full = 1'b0;
        m_owner  = NUM_IN - 1;
        m_cnt    = 0;
        m_held   = 1'b0;
        for (int i = 0; i < NUM_IN; i++) nxt[i] = 0;
        drive_src();
        #1 rst = 1'b1;
        do_reset();

        // All sources empty: idle, owner stays at NUM_IN-1.
        for (int c = 0; c < 10; c++) step(1'b0, 1'b0);

        // Every source preloaded with 4 tokens, sink always ready.
        for (int i = 0; i < NUM_IN; i++) load(i, 4);
        sink_log.delete();
        for (int c = 0; c < 17; c++) step(1'b0, 1'b0);
        #3;
        exp_log = {8'h00, 8'h01, 8'h10, 8'h11, 8'h20, 8'h21, 8'h30, 8'h31,
                   8'h02, 8'h03, 8'h12, 8'h13, 8'h22, 8'h23, 8'h32, 8'h33};
        check_log("order_all4", exp_log);

        // Only source 2 has data: back-to-back delivery despite BURST.
        do_reset();
        for (int i = 0; i < NUM_IN; i++) nxt[i] = 0;
        load(2, 5);
        sink_log.delete();
        for (int c = 0; c < 7; c++) step(1'b0, 1'b0);
        #3;
        exp_log = {8'h20, 8'h21, 8'h22, 8'h23, 8'h24};
        check_log("only_src2", exp_log);
        chk("only_src2_grant", 32'(grant_idx), 32'd2);

        // Sink full for 3 cycles while a token is staged.
        do_reset();
        for (int i = 0; i < NUM_IN; i++) nxt[i] = 0;
        load(0, 3);
        sink_log.delete();
        step(1'b0, 1'b0);
        for (int c = 0; c < 3; c++) step(1'b1, 1'b0);
        chk("stall_no_write", 32'(sink_log.size()), 32'd0);
        for (int c = 0; c < 3; c++) step(1'b0, 1'b0);
        #3;
        exp_log = {8'h00, 8'h01, 8'h02};
        check_log("stall", exp_log);

        // Source 1 runs dry mid-burst while source 3 is ready.
        do_reset();
        for (int i = 0; i < NUM_IN; i++) nxt[i] = 0;
        load(1, 1);
        load(3, 2);
        sink_log.delete();
        for (int c = 0; c < 4; c++) step(1'b0, 1'b0);
        #3;
        exp_log = {8'h10, 8'h30, 8'h31};
        check_log("owner_empties", exp_log);

        // Randomized traffic with a reset asserted while a token is staged.
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            step($urandom_range(3) == 0, 1'b1);
            if (c == 700) begin
                guard = 0;
                while (!m_held && guard < 50) begin
                    step(1'b1, 1'b1);
                    guard++;
                end
                chk("hold_timeout", 32'(m_held), 32'd1);
                do_reset();
                load(0, 1);
                load(2, 1);
            end
        end

        for (int c = 0; c < 40; c++) step(1'b0, 1'b0);
        #3;
        chk("drain_scoreboard", 32'(exp_q.size()), 32'd0);
        for (int i = 0; i < NUM_IN; i++) chk("drain_source", 32'(src_q[i].size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
